// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mdu_pkg;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_MULH  = 3'b101;
    localparam logic [2:0] OP_DIV   = 3'b110;
    localparam logic [2:0] OP_REM   = 3'b111;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_seq_if.sv
// Request/writeback bundle between execute stage, mdu_seq and the register bank.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while busy.
interface mdu_seq_if #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 4
);
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [REG_AW-1:0] rd_addr;
    logic              flush;
    logic              busy;
    logic              done;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (
        output start, op, a, b, rd_addr, flush,
        input  busy, done, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, op, a, b, rd_addr, flush,
        output busy, done, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/mdu_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) iteration over {acc, q}.
// Latency: combinational.
// Backpressure: n/a.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        rem_sh  = {acc, q[WIDTH-1]};
        diff    = rem_sh - {1'b0, m};
        acc_nxt = '0;
        q_nxt   = '0;
        if (!is_div) begin
            // Multiplier bits drain out of q[0] while product bits fill in from the top.
            acc_nxt = sum[WIDTH:1];
            q_nxt   = {sum[0], q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_nxt = diff[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = rem_sh[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative 32-step multiply/divide with single-cycle register-bank writeback.
// Latency: result/wr_en 33 cycles after accepted start; signed ops via MDU_SIGNED_EN.
// Backpressure: start ignored while busy (no queueing); flush aborts without writeback.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    mdu_seq_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);

    state_t            state, state_nxt;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  acc, q, m;
    logic [WIDTH-1:0]  acc_n, q_n;
    logic [1:0]        op_r;
    logic [REG_AW-1:0] rd_r;
    logic              neg_r;
    logic [REG_AW-1:0] wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;

    logic              accept;
    logic              last_iter;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              neg_in;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]  res;

    assign accept    = (state == S_IDLE) && bus.start && !bus.flush;
    assign last_iter = (count == CW'(WIDTH-1));

`ifdef MDU_SIGNED_EN
    logic sgn, sa, sb;
    assign sgn   = bus.op[2] && (bus.op[1:0] != 2'b00);
    assign sa    = sgn && bus.a[WIDTH-1];
    assign sb    = sgn && bus.b[WIDTH-1];
    assign a_mag = sa ? -bus.a : bus.a;
    assign b_mag = sb ? -bus.b : bus.b;

    // A zero divisor keeps the all-ones quotient unsigned; the remainder follows the dividend.
    always_comb begin
        neg_in = 1'b0;
        case (bus.op[1:0])
            OP_MULH[1:0]: neg_in = sa ^ sb;
            OP_DIV[1:0]:  neg_in = (sa ^ sb) && (bus.b != '0);
            OP_REM[1:0]:  neg_in = sa;
            default:      neg_in = 1'b0;
        endcase
    end
`else
    logic unused_op2;
    assign unused_op2 = bus.op[2];
    assign a_mag      = bus.a;
    assign b_mag      = bus.b;
    assign neg_in     = 1'b0;
`endif

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_r[1]),
        .acc     (acc),
        .q       (q),
        .m       (m),
        .acc_nxt (acc_n),
        .q_nxt   (q_n)
    );

    always_comb begin
        prod = {acc_n, q_n};
        if (neg_r) prod = -prod;
        case (op_r)
            OP_MUL[1:0]:   res = prod[WIDTH-1:0];
            OP_MULHU[1:0]: res = prod[2*WIDTH-1:WIDTH];
            OP_DIVU[1:0]:  res = neg_r ? -q_n : q_n;
            default:       res = neg_r ? -acc_n : acc_n;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CALC;
            S_CALC: begin
                if (bus.flush)     state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != S_IDLE);
        bus.done  = (state == S_DONE);
        bus.wr_en = (state == S_DONE) && (rd_r != '0);
    end

    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            op_r      <= '0;
            rd_r      <= '0;
            neg_r     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (accept) begin
            count <= '0;
            acc   <= '0;
            op_r  <= bus.op[1:0];
            rd_r  <= bus.rd_addr;
            neg_r <= neg_in;
            // Multiply: q holds the multiplier. Divide: q holds the dividend.
            q     <= bus.op[1] ? a_mag : b_mag;
            m     <= bus.op[1] ? b_mag : a_mag;
        end else if (state == S_CALC && !bus.flush) begin
            acc   <= acc_n;
            q     <= q_n;
            count <= count + 1'b1;
            if (last_iter) begin
                wr_data_q <= res;
                wr_addr_q <= rd_r;
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed and randomized bench for mdu_seq against an arithmetic reference model.
// Latency: checks the 33-cycle result timing. Backpressure: checks ignored start and flush.
module tb_mdu_seq;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    mdu_seq_if #(.WIDTH(32), .REG_AW(4)) bus ();

    mdu_seq #(.WIDTH(32), .REG_AW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [63:0] sp;
        logic [2:0]         o;
`ifdef MDU_SIGNED_EN
        o = op;
`else
        o = {1'b0, op[1:0]};
`endif
        p  = {32'b0, a} * {32'b0, b};
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (o)
            3'd0, 3'd4: return p[31:0];
            3'd1:       return p[63:32];
            3'd2:       return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd3:       return (b == 0) ? a : a % b;
            3'd5:       return sp[63:32];
            3'd6: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
        endcase
    endfunction

    // Issue one op, scramble the inputs afterwards, wait for done and check timing/writeback.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [3:0] rd, input bit poke);
        logic [31:0] expv;
        int          k;
        bit          seen;
        int          extra;
        expv = model(op, av, bv);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = av; bus.b = bv; bus.rd_addr = rd;
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom);
        bus.rd_addr = 4'($urandom);
        k = 1;
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        seen = 1'b0;
        while (k < 100) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            bus.start = poke && (k == 5 || k == 20);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, 32'(k), 32'd33);
        chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(rd != 0));
        chk({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(rd));
        chk({tag, ".wr_data"}, bus.wr_data, expv);
        @(negedge clk);
        chk({tag, ".done_low"}, 32'(bus.done), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            chk({tag, ".no_second"}, 32'(extra), 32'd0);
        end
    endtask

    task automatic no_done_for(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done || bus.wr_en) cnt++;
        end
        chk(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        bus.rd_addr = '0; bus.flush = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst.wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst.wr_data", bus.wr_data, 32'd0);
        reset_n = 1'b1;

        run_op("mul7x6", 3'b000, 32'd7, 32'd6, 4'd3, 1'b0);
        run_op("mulhu_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 1'b0);
        run_op("mul_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1'b0);
        run_op("divu", 3'b010, 32'd100, 32'd7, 4'd6, 1'b0);
        run_op("remu", 3'b011, 32'd100, 32'd7, 4'd7, 1'b0);
        run_op("divu0", 3'b010, 32'd5, 32'd0, 4'd8, 1'b0);
        run_op("remu0", 3'b011, 32'd5, 32'd0, 4'd9, 1'b0);
        run_op("busy_start", 3'b000, 32'd123, 32'd456, 4'd10, 1'b1);
        run_op("rd0", 3'b000, 32'd3, 32'd3, 4'd0, 1'b0);

        // Flush ten cycles into CALC.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd11; bus.b = 32'd13; bus.rd_addr = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush.busy", 32'(bus.busy), 32'd0);
        chk("flush.done", 32'(bus.done), 32'd0);
        chk("flush.wr_en", 32'(bus.wr_en), 32'd0);
        no_done_for("flush.quiet", 40);

        // Flush together with start in IDLE: nothing accepted.
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start.busy", 32'(bus.busy), 32'd0);
        no_done_for("flush_start.quiet", 40);

        run_op("after_flush", 3'b000, 32'd9, 32'd9, 4'd5, 1'b0);

        // Reset in the middle of CALC.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd1000; bus.b = 32'd3; bus.rd_addr = 4'd12;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid.busy", 32'(bus.busy), 32'd0);
        chk("rst_mid.done", 32'(bus.done), 32'd0);
        chk("rst_mid.wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_mid.wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_mid.wr_data", bus.wr_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        no_done_for("rst_mid.quiet", 40);

`ifdef MDU_SIGNED_EN
        run_op("div_s", 3'b110, 32'hFFFF_FFF9, 32'd2, 4'd1, 1'b0);
        run_op("rem_s", 3'b111, 32'hFFFF_FFF9, 32'd2, 4'd1, 1'b0);
        run_op("div_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 4'd2, 1'b0);
        run_op("mulh_m1", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 1'b0);
        run_op("rem_s0", 3'b111, 32'hFFFF_FF00, 32'd0, 4'd4, 1'b0);
`else
        run_op("div_1xx", 3'b110, 32'hFFFF_FFF9, 32'd2, 4'd1, 1'b0);
        run_op("mulh_1xx", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), 3'($urandom), ra, rb, 4'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
